mult_arbiter: RTL and testbench
===============================

# mult_arbiter

Shares the sequential 16x16 shift-add multiplier between two requesters (e.g. the MIPS `mult` execute path and a second client). It serialises requests with round-robin priority, latches the granted operands, and pulses the multiplier's `start`. It then waits for `done`, returns the 32-bit product with a one-cycle acknowledge, and flags a watchdog timeout if the multiplier never finishes. It sits between the requesters and the multiplier instance, which remains a separate module.

## Interface
- `WIDTH`, 16: operand width; product is 2*WIDTH.
- `TIMEOUT`, 48: maximum cycles from `m_start` to `m_done` before an error response.
- `clk` input 1: single clock, all logic on rising edge.
- `rst_n` input 1: synchronous reset, active-low.
- `req0`, `req1` input 1: request; held high with operands stable until the matching ack.
- `a0`, `b0`, `a1`, `b1` input WIDTH: multiplicand / multiplier per requester.
- `ack0`, `ack1` output 1: one-cycle response pulse to the granted requester.
- `result` output 2*WIDTH: product, valid while the ack pulse is high; holds its value afterwards.
- `err` output 1: valid with the ack pulse; 1 = timeout, and `result` is then 0.
- `busy` output 1: high in any state other than IDLE.
- `m_multiplicando`, `m_multiplicador` output WIDTH: latched operands to the multiplier.
- `m_start` output 1: one-cycle start pulse to the multiplier.
- `m_idle` input 1: multiplier ready to accept start.
- `m_done` input 1: product valid on `m_produto` in this cycle.
- `m_produto` input 2*WIDTH: multiplier product.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Sample eligible requests.
  - If either is eligible, latch the winner's operands into `m_multiplicando`/`m_multiplicador`, record the grant id, and go to ISSUE.
- Round-robin arbitration:
  - `last` holds the id of the most recent grant and resets to 1, so `req0` wins the first contest.
  - If both requests are eligible, grant `!last`. If only one is eligible, grant it.
  - `last` updates at grant time.
- Holdoff: in the IDLE cycle immediately after an ack, the just-acked requester's `req` is ignored. This absorbs a registered requester that drops `req` one cycle late. The other requester is not masked.
- ISSUE:
  - If `m_idle`=1, assert `m_start` for this cycle, clear the watchdog counter, and go to WAIT.
  - Otherwise stay in ISSUE with `m_start`=0.
  - `m_done` is ignored in ISSUE.
- WAIT: the counter increments each cycle.
  - If `m_done`=1, register `m_produto` into `result`, set `err`=0, and go to RESP.
  - Otherwise, when the counter reaches TIMEOUT-1, set `result`=0, set `err`=1, and go to RESP.
  - `m_done` takes precedence in the same cycle.
- RESP: assert the ack for the granted id for exactly one cycle, then go to IDLE.
- Operand registers hold their value until the next grant. The multiplier sees stable operands for the whole operation.
- Arithmetic: none inside this block. `result` is a straight copy of `m_produto`, unsigned, no truncation.

## Timing
- Reset values: state=IDLE, `last`=1, all outputs 0 (`ack0`, `ack1`, `err`, `busy`, `m_start`, `result`, `m_multiplicando`, `m_multiplicador`), watchdog counter 0.
- Latency:
  - `req` high in IDLE at cycle 0.
  - `m_start` high in cycle 1, provided `m_idle`=1.
  - `m_done` high in cycle 1+L.
  - Ack high in cycle 2+L.
  - Total response = L+2 cycles after the sampled request, plus any extra ISSUE cycles spent waiting for `m_idle`.
- Back-to-back: earliest next grant is in the cycle after the ack. With both requesters continuously requesting, grants strictly alternate.
- `m_start` is never high outside ISSUE and is never high for two consecutive cycles.
- `busy` is a registered decode of state (high in ISSUE/WAIT/RESP).
- Reset mid-operation (`rst_n`=0 sampled in any state): return to IDLE next cycle with no ack issued and the operation discarded. The multiplier is not reset by this block; a stale `m_done` arriving while in IDLE is ignored.
- Request withdrawn after grant: the operation still completes and the ack is still pulsed.
- `req` of the non-granted requester is ignored until the block returns to IDLE.

## Test plan
- Single request: `req0`=1, `a0`=3, `b0`=5, multiplier model with L=17 → exactly one `m_start` pulse; `ack0` at cycle 19; `result`=15; `err`=0; `ack1` never asserted.
- Simultaneous requests after reset: `req0`/`req1` both high with (7,9) and (65535,65535) → `ack0` first with 63; then `ack1` with 32'hFFFE0001; grants alternate for 4 more rounds.
- Busy multiplier: `m_idle`=0 for 5 cycles after grant → ISSUE held 5 cycles with `m_start`=0; `m_start` pulses on the first cycle `m_idle`=1; ack latency grows by 5.
- Timeout: `m_done` never asserted, TIMEOUT=48 → ack in cycle 49 after `m_start`; `err`=1; `result`=0; next request is then served normally.
- Reset mid-WAIT: `rst_n`=0 for one cycle at cycle 8, then a late `m_done` at cycle 17 → no ack; `busy`=0 after reset; all outputs at reset values; the next `req1` is granted after `req0` per `last`=1.
- Holdoff: `req0` dropped one cycle after `ack0` while `req1`=0 → no second grant to requester 0; `busy` stays 0.

Source files
------------

// File: rtl/mult_arbiter_if.sv
// Requester and multiplier-side signals of mult_arbiter, bundled as one bus.
// slave is the arbiter's view; master is the environment's (requesters plus multiplier).
interface mult_arbiter_if #(
    parameter int WIDTH = 16
);
    logic                 req0;
    logic                 req1;
    logic [WIDTH-1:0]     a0;
    logic [WIDTH-1:0]     b0;
    logic [WIDTH-1:0]     a1;
    logic [WIDTH-1:0]     b1;
    logic                 ack0;
    logic                 ack1;
    logic [2*WIDTH-1:0]   result;
    logic                 err;
    logic                 busy;
    logic [WIDTH-1:0]     m_multiplicando;
    logic [WIDTH-1:0]     m_multiplicador;
    logic                 m_start;
    logic                 m_idle;
    logic                 m_done;
    logic [2*WIDTH-1:0]   m_produto;

    modport slave (
        input  req0, req1, a0, b0, a1, b1, m_idle, m_done, m_produto,
        output ack0, ack1, result, err, busy, m_multiplicando, m_multiplicador, m_start
    );

    modport master (
        output req0, req1, a0, b0, a1, b1, m_idle, m_done, m_produto,
        input  ack0, ack1, result, err, busy, m_multiplicando, m_multiplicador, m_start
    );
endinterface

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one sequential multiplier between two requesters,
// with a watchdog that turns a missing m_done into an error response.
module mult_arbiter #(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 48
) (
    input  logic              clk,
    input  logic              rst_n,
    mult_arbiter_if.slave     bus
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t             state_q, state_d;
    logic               last_q, last_d;
    logic               gid_q, gid_d;
    logic [WIDTH-1:0]   op_a_q, op_a_d;
    logic [WIDTH-1:0]   op_b_q, op_b_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               err_q, err_d;
    logic               ack0_q, ack0_d;
    logic               ack1_q, ack1_d;
    logic               hold0_q, hold0_d;
    logic               hold1_q, hold1_d;
    logic               busy_q, busy_d;
    logic               m_start;
    logic               grant1;
    logic               elig0, elig1;

    // The requester acked last cycle may still show a stale req for one cycle.
    assign elig0 = bus.req0 && !hold0_q;
    assign elig1 = bus.req1 && !hold1_q;

    always_comb begin
        // NOTE: every signal gets a default here so no path can infer a latch.
        state_d  = state_q;
        last_d   = last_q;
        gid_d    = gid_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        err_d    = err_q;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        hold0_d  = ack0_q;
        hold1_d  = ack1_q;
        m_start  = 1'b0;
        grant1   = elig1 && (!elig0 || !last_q);

        unique case (state_q)
            IDLE: begin
                if (elig0 || elig1) begin
                    gid_d   = grant1;
                    last_d  = grant1;
                    op_a_d  = grant1 ? bus.a1 : bus.a0;
                    op_b_d  = grant1 ? bus.b1 : bus.b0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.m_idle) begin
                    m_start = 1'b1;
                    cnt_d   = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (bus.m_done) begin
                    result_d = bus.m_produto;
                    err_d    = 1'b0;
                    ack0_d   = !gid_q;
                    ack1_d   = gid_q;
                    state_d  = RESP;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    result_d = '0;
                    err_d    = 1'b1;
                    ack0_d   = !gid_q;
                    ack1_d   = gid_q;
                    state_d  = RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            state_q  <= IDLE;
            last_q   <= 1'b1;
            gid_q    <= 1'b0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            hold0_q  <= 1'b0;
            hold1_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            gid_q    <= gid_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            err_q    <= err_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            hold0_q  <= hold0_d;
            hold1_q  <= hold1_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.ack0            = ack0_q;
    assign bus.ack1            = ack1_q;
    assign bus.result          = result_q;
    assign bus.err             = err_q;
    assign bus.busy            = busy_q;
    assign bus.m_multiplicando = op_a_q;
    assign bus.m_multiplicador = op_b_q;
    assign bus.m_start         = m_start;
endmodule

// File: tb/tb_mult_arbiter.sv
// Self-checking bench for mult_arbiter: latency-programmable multiplier model
// plus a scoreboard of expected responses popped on each ack.
module tb_mult_arbiter;
    localparam int W  = 16;
    localparam int PW = 2 * W;
    localparam int TO = 48;

    typedef struct {
        logic          id;
        logic [PW-1:0] res;
        logic          err;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mult_arbiter_if #(.WIDTH(W)) bus ();
    mult_arbiter #(.WIDTH(W), .TIMEOUT(TO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    exp_t          sb[$];
    int            n_tests = 0;
    int            n_fail  = 0;
    int            cyc     = 0;
    int            n_start = 0;
    int            n_ack   = 0;
    int            last_start_cyc = 0;
    bit            prev_start = 1'b0;
    int            mdl_lat = 17;
    bit            mdl_en  = 1'b1;
    int            mdl_cnt = -1;
    logic [PW-1:0] mdl_p   = '0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic wait_ack(output int c);
        bit got = 1'b0;
        c = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.ack0 || bus.ack1) begin
                got = 1'b1;
                c   = cyc;
                break;
            end
        end
        if (!got) check("ack_wait_expired", 0, 1);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_busy",   bus.busy, 0);
        check("rst_ack",    {bus.ack1, bus.ack0}, 0);
        check("rst_err",    bus.err, 0);
        check("rst_result", bus.result, 0);
        check("rst_ops",    {bus.m_multiplicando, bus.m_multiplicador}, 0);
        check("rst_start",  bus.m_start, 0);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: start-pulse rules, multiplier model launch, scoreboard pop on ack.
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (bus.m_start) begin
                check("start_twice", prev_start, 0);
                check("start_busy", bus.busy, 1);
                n_start++;
                last_start_cyc = cyc;
                mdl_cnt = mdl_lat;
                mdl_p   = PW'(bus.m_multiplicando) * PW'(bus.m_multiplicador);
            end
            if (bus.ack0 || bus.ack1) begin
                n_ack++;
                if (sb.size() == 0) begin
                    check("ack_unexpected", {bus.ack1, bus.ack0}, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("ack_id", {bus.ack1, bus.ack0}, e.id ? 2'b10 : 2'b01);
                    check("result", bus.result, e.res);
                    check("err",    bus.err,    e.err);
                end
            end
        end
        prev_start = bus.m_start;
    end

    // Multiplier model: m_done exactly mdl_lat cycles after the start cycle.
    initial begin
        bus.m_done    = 1'b0;
        bus.m_produto = '0;
        bus.m_idle    = 1'b1;
        forever begin
            next_cycle();
            bus.m_done    = 1'b0;
            bus.m_produto = PW'($urandom);
            if (mdl_cnt > 0) begin
                mdl_cnt--;
                if (mdl_cnt == 0) begin
                    mdl_cnt = -1;
                    if (mdl_en) begin
                        bus.m_done    = 1'b1;
                        bus.m_produto = mdl_p;
                    end
                end
            end
        end
    end

    initial begin
        int t0, c, s0, a0n;
        logic [W-1:0] x, y;
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        bus.a0 = '0; bus.b0 = '0; bus.a1 = '0; bus.b1 = '0;
        apply_reset();

        // Single request, L=17
        next_cycle();
        bus.a0 = 16'd3; bus.b0 = 16'd5; bus.req0 = 1'b1;
        t0 = cyc; s0 = n_start; a0n = n_ack;
        sb.push_back('{1'b0, PW'(15), 1'b0});
        wait_ack(c);
        check("t1_latency", c - t0, 19);
        next_cycle();
        bus.req0 = 1'b0;
        repeat (5) @(negedge clk);
        check("t1_starts", n_start - s0, 1);
        check("t1_acks", n_ack - a0n, 1);

        // Simultaneous requests after reset, six alternating grants
        apply_reset();
        next_cycle();
        bus.a0 = 16'd7; bus.b0 = 16'd9; bus.a1 = 16'hFFFF; bus.b1 = 16'hFFFF;
        bus.req0 = 1'b1; bus.req1 = 1'b1; t0 = cyc;
        sb.push_back('{1'b0, PW'(63), 1'b0});
        sb.push_back('{1'b1, 32'hFFFE0001, 1'b0});
        for (int i = 1; i <= 6; i++) begin
            wait_ack(c);
            if (i == 1) check("t2_latency", c - t0, 19);
            next_cycle();
            x = W'($urandom); y = W'($urandom);
            if (i <= 4) begin
                if (i % 2 == 1) begin bus.a0 = x; bus.b0 = y; end
                else            begin bus.a1 = x; bus.b1 = y; end
                sb.push_back('{(i % 2 == 0), PW'(x) * PW'(y), 1'b0});
            end else if (i == 5) begin
                bus.req0 = 1'b0;
            end else begin
                bus.req1 = 1'b0;
            end
        end

        // Busy multiplier: m_idle low for the first 5 ISSUE cycles
        next_cycle();
        bus.a1 = 16'd1000; bus.b1 = 16'd3000; bus.req1 = 1'b1;
        bus.m_idle = 1'b0; t0 = cyc; s0 = n_start;
        sb.push_back('{1'b1, PW'(3000000), 1'b0});
        repeat (6) @(posedge clk);
        #1;
        check("t3_no_start", n_start - s0, 0);
        bus.m_idle = 1'b1;
        wait_ack(c);
        check("t3_start_cyc", last_start_cyc - t0, 6);
        check("t3_latency", c - t0, 24);
        next_cycle();
        bus.req1 = 1'b0;

        // Watchdog timeout, then a normal request
        mdl_en = 1'b0;
        next_cycle();
        bus.a0 = W'($urandom); bus.b0 = W'($urandom) | 16'h1; bus.req0 = 1'b1;
        sb.push_back('{1'b0, PW'(0), 1'b1});
        wait_ack(c);
        check("t4_timeout_lat", c - last_start_cyc, 49);
        next_cycle();
        bus.req0 = 1'b0; mdl_en = 1'b1;
        x = W'($urandom); y = W'($urandom);
        bus.a1 = x; bus.b1 = y; bus.req1 = 1'b1; t0 = cyc;
        sb.push_back('{1'b1, PW'(x) * PW'(y), 1'b0});
        wait_ack(c);
        check("t4_after_lat", c - t0, 19);
        next_cycle();
        bus.req1 = 1'b0;

        // Reset mid-WAIT with a stale m_done arriving later
        mdl_lat = 16;
        next_cycle();
        bus.a0 = 16'd11; bus.b0 = 16'd13; bus.req0 = 1'b1; t0 = cyc; a0n = n_ack;
        while (cyc < t0 + 8) next_cycle();
        rst_n = 1'b0; bus.req0 = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        check("t5_busy",   bus.busy, 0);
        check("t5_result", bus.result, 0);
        check("t5_ops",    {bus.m_multiplicando, bus.m_multiplicador}, 0);
        check("t5_ackerr", {bus.ack1, bus.ack0, bus.err}, 0);
        while (cyc < t0 + 20) next_cycle();
        check("t5_no_ack", n_ack - a0n, 0);
        check("t5_idle",   bus.busy, 0);
        mdl_lat = 17;
        bus.a0 = 16'd2; bus.b0 = 16'd21; bus.a1 = 16'd300; bus.b1 = 16'd400;
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        sb.push_back('{1'b0, PW'(42), 1'b0});
        sb.push_back('{1'b1, PW'(120000), 1'b0});
        wait_ack(c);
        next_cycle();
        bus.req0 = 1'b0;
        wait_ack(c);
        next_cycle();
        bus.req1 = 1'b0;

        // Holdoff: req0 drops one cycle late after its ack
        next_cycle();
        bus.a0 = 16'd250; bus.b0 = 16'd4; bus.req0 = 1'b1;
        sb.push_back('{1'b0, PW'(1000), 1'b0});
        wait_ack(c);
        s0 = n_start; a0n = n_ack;
        next_cycle();
        next_cycle();
        bus.req0 = 1'b0;
        repeat (6) @(negedge clk);
        check("t6_busy",   bus.busy, 0);
        check("t6_starts", n_start - s0, 0);
        check("t6_acks",   n_ack - a0n, 0);

        check("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
